// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-memory arbiter.
//   NUM_PORTS   number of requesters (core LSU and debug loader)
//   PORT_CORE   requester index of the core load/store unit
//   PORT_DBG    requester index of the debug/program loader
//   LOCK_MAX    longest run of consecutive grants one lock may hold
//   *_DEF       default widths and memory depth
package dmem_arb_pkg;

   localparam int unsigned NUM_PORTS  = 2;
   localparam int unsigned PORT_CORE  = 0;
   localparam int unsigned PORT_DBG   = 1;
   localparam int unsigned LOCK_MAX   = 4;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DEPTH_DEF  = 32;

   // cnt counts grants already taken under the lock, minus one.
   typedef struct packed {
      logic       valid;
      logic       port;
      logic [1:0] cnt;
   } lock_t;

   localparam lock_t LOCK_NONE = '{valid: 1'b0, port: 1'b0, cnt: 2'd0};

   function automatic logic [NUM_PORTS-1:0] onehot2(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for dmem_arbiter.
//   req_i/we_i/lock_i       per-port request, write enable, lock
//   addr0_i/addr1_i         per-port word address
//   wd0_i/wd1_i             per-port write data
//   gnt_o/rvalid_o/err_o    per-port grant and response pulses
//   rdata_o                 shared read data
//   mem_addr_o/mem_wd_o/mem_we_o/mem_rd_i   memory pins
// Modports: slave = arbiter side, master = requester/memory environment side.
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

   logic [NUM_PORTS-1:0] req_i;
   logic [NUM_PORTS-1:0] we_i;
   logic [NUM_PORTS-1:0] lock_i;
   logic [ADDR_W-1:0]    addr0_i;
   logic [ADDR_W-1:0]    addr1_i;
   logic [DATA_W-1:0]    wd0_i;
   logic [DATA_W-1:0]    wd1_i;
   logic [NUM_PORTS-1:0] gnt_o;
   logic [NUM_PORTS-1:0] rvalid_o;
   logic [NUM_PORTS-1:0] err_o;
   logic [DATA_W-1:0]    rdata_o;
   logic [ADDR_W-1:0]    mem_addr_o;
   logic [DATA_W-1:0]    mem_wd_o;
   logic                 mem_we_o;
   logic [DATA_W-1:0]    mem_rd_i;

   modport slave (
      input  req_i, we_i, lock_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
      output gnt_o, rvalid_o, err_o, rdata_o, mem_addr_o, mem_wd_o, mem_we_o
   );

   modport master (
      output req_i, we_i, lock_i, addr0_i, addr1_i, wd0_i, wd1_i, mem_rd_i,
      input  gnt_o, rvalid_o, err_o, rdata_o, mem_addr_o, mem_wd_o, mem_we_o
   );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker with lock override.
//   req_i        per-port request
//   lock_en_i    a lock is held and still has grants left
//   lock_port_i  port owning the lock
//   rr_ptr_i     favoured port when both request
//   gnt_o        one-hot or zero pick
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req_i,
   input  logic                 lock_en_i,
   input  logic                 lock_port_i,
   input  logic                 rr_ptr_i,
   output logic [NUM_PORTS-1:0] gnt_o
);

   always_comb begin
      gnt_o = '0;
      if (lock_en_i && req_i[lock_port_i]) begin
         gnt_o = onehot2(lock_port_i);
      end else begin
         case (req_i)
            2'b01:   gnt_o = onehot2(1'(PORT_CORE));
            2'b10:   gnt_o = onehot2(1'(PORT_DBG));
            2'b11:   gnt_o = onehot2(rr_ptr_i);
            default: gnt_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core LSU (port 0) and the
// debug loader (port 1). Round-robin with a bounded lock, bounds check against
// DEPTH, one-cycle registered read/error response.
//   clk   clock, all state on posedge
//   rst   synchronous active-high reset
//   bus   dmem_arbiter_if.slave: requester handshake, responses, memory pins
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   logic                 rr_ptr_q, rr_ptr_d;
   lock_t                lock_q, lock_d;
   logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
   logic [NUM_PORTS-1:0] err_q, err_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;

   logic [NUM_PORTS-1:0] pick, gnt;
   logic                 gnt_any, gnt_port, lock_en, sel_we, in_range, rd_ok;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wd;

   // The last allowed grant of a lock run is cnt == LOCK_MAX-1; past that the
   // lock stops overriding round-robin.
   assign lock_en = lock_q.valid && (lock_q.cnt != 2'(LOCK_MAX - 1));

   rr_arb2 u_rr_arb2 (
      .req_i       (bus.req_i),
      .lock_en_i   (lock_en),
      .lock_port_i (lock_q.port),
      .rr_ptr_i    (rr_ptr_q),
      .gnt_o       (pick)
   );

   always_comb begin
      gnt      = rst ? '0 : pick;
      gnt_any  = |gnt;
      gnt_port = gnt[PORT_DBG];
      sel_addr = '0;
      sel_wd   = '0;
      sel_we   = 1'b0;
      if (gnt_any) begin
         sel_addr = gnt_port ? bus.addr1_i : bus.addr0_i;
         sel_wd   = gnt_port ? bus.wd1_i   : bus.wd0_i;
         sel_we   = bus.we_i[gnt_port];
      end
      in_range = sel_addr < ADDR_W'(DEPTH);
      rd_ok    = gnt_any && !sel_we && in_range;
   end

   assign bus.gnt_o      = gnt;
   assign bus.mem_addr_o = sel_addr;
   assign bus.mem_wd_o   = sel_wd;
   assign bus.mem_we_o   = gnt_any && sel_we && in_range;
   assign bus.rvalid_o   = rvalid_q;
   assign bus.err_o      = err_q;
   assign bus.rdata_o    = rdata_q;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      lock_d   = LOCK_NONE;
      rvalid_d = rd_ok ? gnt : '0;
      err_d    = (gnt_any && !in_range) ? gnt : '0;
      rdata_d  = rd_ok ? bus.mem_rd_i : '0;
      // No grant outside reset means nobody requests, so any lock is released.
      if (gnt_any) begin
         rr_ptr_d = ~gnt_port;
         if (bus.lock_i[gnt_port]) begin
            lock_d.valid = 1'b1;
            lock_d.port  = gnt_port;
            // Continue the run only when this grant came from the lock itself.
            lock_d.cnt   = (lock_en && (lock_q.port == gnt_port)) ? lock_q.cnt + 2'd1 : 2'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
         lock_q   <= LOCK_NONE;
         rvalid_q <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         lock_q   <= lock_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic clk;
   logic rst;

   dmem_arbiter_if bus ();

   dmem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: combinational read, posedge write.
   logic [31:0] mem [32];
   assign bus.mem_rd_i = (bus.mem_addr_o < 32'd32) ? mem[bus.mem_addr_o[4:0]] : 32'd0;
   always @(posedge clk) if (bus.mem_we_o) mem[bus.mem_addr_o[4:0]] <= bus.mem_wd_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [31:0] shadow [32];
   int          fav = 0;      // port favoured when both request
   int          lk_own = -1;  // lock owner, -1 = none
   int          lk_run = 0;   // grants taken in the current lock run
   logic        m_rst;
   int          m_p;
   logic        m_honour;
   logic [1:0]  m_lock;
   logic [1:0]  e_gnt;
   logic        e_we;
   logic [31:0] e_addr, e_wd;
   logic [1:0]  pend_rv, pend_err, e_rv, e_err;
   logic [31:0] pend_rd, e_rd;

   // Drive one cycle's inputs at negedge and predict this cycle's issue and the
   // response it will produce next cycle.
   task automatic apply(input logic r, input logic [1:0] req, input logic [1:0] we,
                        input logic [1:0] lk, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
      logic [31:0] ad, dd;
      logic        inr;
      @(negedge clk);
      rst = r;
      bus.req_i = req; bus.we_i = we; bus.lock_i = lk;
      bus.addr0_i = a0; bus.addr1_i = a1; bus.wd0_i = d0; bus.wd1_i = d1;
      m_rst = r; m_lock = lk; m_p = -1; m_honour = 1'b0;
      if (!r) begin
         m_honour = (lk_own >= 0) && req[lk_own] && (lk_run < 4);
         if (m_honour)          m_p = lk_own;
         else if (req == 2'b11) m_p = fav;
         else if (req == 2'b01) m_p = 0;
         else if (req == 2'b10) m_p = 1;
      end
      ad  = (m_p == 1) ? a1 : a0;
      dd  = (m_p == 1) ? d1 : d0;
      inr = ad < 32;
      e_gnt    = (m_p < 0) ? 2'b00 : ((m_p == 1) ? 2'b10 : 2'b01);
      e_addr   = (m_p < 0) ? 32'd0 : ad;
      e_wd     = (m_p < 0) ? 32'd0 : dd;
      e_we     = (m_p >= 0) && we[m_p] && inr;
      pend_rv  = ((m_p >= 0) && !we[m_p] && inr) ? e_gnt : 2'b00;
      pend_err = ((m_p >= 0) && !inr) ? e_gnt : 2'b00;
      pend_rd  = (pend_rv != 2'b00) ? shadow[ad[4:0]] : 32'd0;
      #1;
   endtask

   // Cross the posedge and update the model to match.
   task automatic advance();
      @(posedge clk);
      if (m_rst) begin
         fav = 0; lk_own = -1; lk_run = 0;
         e_rv = 2'b00; e_err = 2'b00; e_rd = 32'd0;
      end else begin
         e_rv = pend_rv; e_err = pend_err; e_rd = pend_rd;
         if (m_p >= 0) begin
            lk_run = m_honour ? lk_run + 1 : 1;
            lk_own = m_lock[m_p] ? m_p : -1;
            fav    = 1 - m_p;
            if (e_we) shadow[e_addr[4:0]] = e_wd;
         end else begin
            lk_own = -1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, 2'b11, 2'b01, 2'b11, 32'd3, 32'd40, 32'd1, 32'd2);
         n_cmp++;
         if ({bus.gnt_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_issue: got gnt=%b we=%b addr=%0h wd=%h, want all zero",
                     bus.gnt_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o);
         end
         advance();
         n_cmp++;
         if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_resp: got rv=%b err=%b rd=%h, want all zero",
                     bus.rvalid_o, bus.err_o, bus.rdata_o);
         end
      end
   endtask

   task automatic test_preload();
      for (int i = 0; i < 32; i++) begin
         apply(1'b0, 2'b10, 2'b10, 2'b00, 32'd0, i, 32'd0, $urandom);
         n_cmp++;
         if ({bus.gnt_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o} !== {e_gnt, e_we, e_addr, e_wd}) begin
            n_bad++;
            $display("FAIL preload_issue[%0d]: got gnt=%b we=%b addr=%0h wd=%h, want %b %b %0h %h",
                     i, bus.gnt_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o,
                     e_gnt, e_we, e_addr, e_wd);
         end
         advance();
      end
   endtask

   task automatic test_rr_reads();
      logic [1:0] want_g [2];
      logic [1:0] want_rv [2];
      logic [1:0] reqs [2];
      want_g[0] = 2'b01; want_g[1] = 2'b10;
      want_rv[0] = 2'b01; want_rv[1] = 2'b10;
      reqs[0] = 2'b11; reqs[1] = 2'b10;
      apply(1'b1, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
      advance();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, reqs[i], 2'b00, 2'b00, 32'd3, 32'd5, 32'd0, 32'd0);
         n_cmp++;
         if (bus.gnt_o !== want_g[i]) begin
            n_bad++;
            $display("FAIL rr_gnt[%0d]: got %b, want %b", i, bus.gnt_o, want_g[i]);
         end
         advance();
         n_cmp++;
         if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !==
             {want_rv[i], 2'b00, shadow[(i == 0) ? 3 : 5]}) begin
            n_bad++;
            $display("FAIL rr_resp[%0d]: got rv=%b err=%b rd=%h, want rv=%b err=00 rd=%h",
                     i, bus.rvalid_o, bus.err_o, bus.rdata_o, want_rv[i],
                     shadow[(i == 0) ? 3 : 5]);
         end
      end
   endtask

   task automatic test_raw();
      apply(1'b0, 2'b01, 2'b01, 2'b00, 32'd7, 32'd0, 32'hDEADBEEF, 32'd0);
      n_cmp++;
      if ({bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o} !== {1'b1, 32'd7, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL raw_write: got we=%b addr=%0h wd=%h, want 1 7 deadbeef",
                  bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o);
      end
      advance();
      n_cmp++;
      if ({bus.rvalid_o, bus.err_o} !== 4'b0000) begin
         n_bad++;
         $display("FAIL raw_wr_resp: got rv=%b err=%b, want 00 00", bus.rvalid_o, bus.err_o);
      end
      apply(1'b0, 2'b10, 2'b00, 2'b00, 32'd0, 32'd7, 32'd0, 32'd0);
      advance();
      n_cmp++;
      if ({bus.rvalid_o, bus.rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL raw_read: got rv=%b rd=%h, want rv=10 rd=deadbeef",
                  bus.rvalid_o, bus.rdata_o);
      end
   endtask

   task automatic test_oor_write();
      logic [31:0] old;
      old = mem[8];
      apply(1'b0, 2'b10, 2'b10, 2'b00, 32'd0, 32'd40, 32'd0, ~old);
      n_cmp++;
      if ({bus.gnt_o, bus.mem_we_o} !== 3'b100) begin
         n_bad++;
         $display("FAIL oor_issue: got gnt=%b we=%b, want gnt=10 we=0", bus.gnt_o, bus.mem_we_o);
      end
      advance();
      n_cmp++;
      if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {2'b00, 2'b10, 32'd0}) begin
         n_bad++;
         $display("FAIL oor_resp: got rv=%b err=%b rd=%h, want rv=00 err=10 rd=0",
                  bus.rvalid_o, bus.err_o, bus.rdata_o);
      end
      n_cmp++;
      if (mem[8] !== old) begin
         n_bad++;
         $display("FAIL oor_mem: got mem[8]=%h, want %h", mem[8], old);
      end
   endtask

   task automatic test_lock();
      logic [1:0] want [6];
      want[0] = 2'b01; want[1] = 2'b01; want[2] = 2'b01;
      want[3] = 2'b01; want[4] = 2'b10; want[5] = 2'b01;
      apply(1'b1, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
      advance();
      for (int i = 0; i < 6; i++) begin
         apply(1'b0, 2'b11, 2'b00, 2'b01, i, i + 10, 32'd0, 32'd0);
         n_cmp++;
         if (bus.gnt_o !== want[i]) begin
            n_bad++;
            $display("FAIL lock_gnt[%0d]: got %b, want %b", i, bus.gnt_o, want[i]);
         end
         advance();
         n_cmp++;
         if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {e_rv, e_err, e_rd}) begin
            n_bad++;
            $display("FAIL lock_resp[%0d]: got rv=%b err=%b rd=%h, want %b %b %h",
                     i, bus.rvalid_o, bus.err_o, bus.rdata_o, e_rv, e_err, e_rd);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply(1'b0, 2'b01, 2'b00, 2'b00, 32'd12, 32'd0, 32'd0, 32'd0);
      advance();
      apply(1'b1, 2'b01, 2'b00, 2'b00, 32'd12, 32'd0, 32'd0, 32'd0);
      n_cmp++;
      if ({bus.gnt_o, bus.mem_we_o, bus.mem_addr_o} !== 35'd0) begin
         n_bad++;
         $display("FAIL rstmid_issue: got gnt=%b we=%b addr=%0h, want all zero",
                  bus.gnt_o, bus.mem_we_o, bus.mem_addr_o);
      end
      advance();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== 36'd0) begin
            n_bad++;
            $display("FAIL rstmid_resp[%0d]: got rv=%b err=%b rd=%h, want all zero",
                     i, bus.rvalid_o, bus.err_o, bus.rdata_o);
         end
         apply(1'b0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
         advance();
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) apply(1'b0, 2'b10, 2'b00, 2'b00, 32'd0, i + 1, 32'd0, 32'd0);
         else       apply(1'b0, 2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
         n_cmp++;
         if (bus.gnt_o !== ((i < 3) ? 2'b10 : 2'b00)) begin
            n_bad++;
            $display("FAIL b2b_gnt[%0d]: got %b, want %b", i, bus.gnt_o,
                     (i < 3) ? 2'b10 : 2'b00);
         end
         if (i > 0) begin
            n_cmp++;
            if ({bus.rvalid_o, bus.rdata_o} !== {2'b10, shadow[i]}) begin
               n_bad++;
               $display("FAIL b2b_resp[%0d]: got rv=%b rd=%h, want rv=10 rd=%h",
                        i, bus.rvalid_o, bus.rdata_o, shadow[i]);
            end
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic        r;
      logic [1:0]  rq, w, l;
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 49) == 0);
         rq = 2'($urandom);
         w  = 2'($urandom);
         l  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         apply(r, rq, w, l, $urandom_range(0, 39), $urandom_range(0, 39), $urandom, $urandom);
         n_cmp++;
         if ({bus.gnt_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o} !== {e_gnt, e_we, e_addr, e_wd}) begin
            n_bad++;
            $display("FAIL rand_issue[%0d]: got gnt=%b we=%b addr=%0h wd=%h, want %b %b %0h %h",
                     i, bus.gnt_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wd_o,
                     e_gnt, e_we, e_addr, e_wd);
         end
         advance();
         n_cmp++;
         if ({bus.rvalid_o, bus.err_o, bus.rdata_o} !== {e_rv, e_err, e_rd}) begin
            n_bad++;
            $display("FAIL rand_resp[%0d]: got rv=%b err=%b rd=%h, want %b %b %h",
                     i, bus.rvalid_o, bus.err_o, bus.rdata_o, e_rv, e_err, e_rd);
         end
      end
      for (int i = 0; i < 32; i++) begin
         n_cmp++;
         if (mem[i] !== shadow[i]) begin
            n_bad++;
            $display("FAIL mem_image[%0d]: got %h, want %h", i, mem[i], shadow[i]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.req_i = 2'b00; bus.we_i = 2'b00; bus.lock_i = 2'b00;
      bus.addr0_i = 32'd0; bus.addr1_i = 32'd0; bus.wd0_i = 32'd0; bus.wd1_i = 32'd0;
      test_reset();
      test_preload();
      test_rr_reads();
      test_raw();
      test_oor_write();
      test_lock();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
